// File: rtl/cu_pkg.sv
// Shared definitions for the image control unit: opcodes, instruction field layout, FSM states.
package cu_pkg;

  typedef enum logic [5:0] {
    OP_ADD     = 6'd1,
    OP_SUB     = 6'd2,
    OP_MOV     = 6'd3,
    OP_DIV     = 6'd4,
    OP_MUL     = 6'd5,
    OP_AND     = 6'd6,
    OP_OR      = 6'd7,
    OP_STR_DAT = 6'd8,
    OP_LDR_DAT = 6'd9,
    OP_STR_IMG = 6'd10,
    OP_LDR_IMG = 6'd11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_TRAP  = 2'd3
  } state_e;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int RD_MSB   = 25;
  localparam int RD_LSB   = 23;
  localparam int RS1_MSB  = 22;
  localparam int RS1_LSB  = 20;
  localparam int RS2_MSB  = 19;
  localparam int RS2_LSB  = 17;
  localparam int IMM1_MSB = 15;
  localparam int IMM1_LSB = 8;
  localparam int IMM2_MSB = 7;
  localparam int IMM2_LSB = 0;

  function automatic logic is_legal(input logic [5:0] op);
    return (op >= 6'd1) && (op <= 6'd11);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LDR_DAT) || (op == OP_LDR_IMG);
  endfunction

  function automatic logic is_alu(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_DIV, OP_MUL, OP_AND, OP_OR: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  // Loads keep their opcode on alu_ctrl so the datapath can steer the returning data.
  function automatic logic [5:0] alu_sel(input logic [5:0] op);
    if (is_alu(op) || is_load(op)) return op;
    return 6'd0;
  endfunction

endpackage

// File: rtl/img_addr_gen.sv
// Post-incrementing image byte-address counter: steps by STRIDE, wraps to 0 at IMG_BYTES,
// and pulses wrap_o during the first cycle the counter sits at 0 after a wrap.
module img_addr_gen
  import cu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int IMG_BYTES = 152100,
  parameter int STRIDE    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wrap_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W:0]   sum;

  // One extra bit so addresses near the top of the range cannot overflow the compare.
  assign sum = {1'b0, addr_q} + (ADDR_W+1)'(STRIDE);

  always_comb begin
    addr_d = addr_q;
    wrap_d = 1'b0;
    if (step_i) begin
      if (sum >= (ADDR_W+1)'(IMG_BYTES)) begin
        addr_d = '0;
        wrap_d = 1'b1;
      end else begin
        addr_d = sum[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr_o = addr_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/img_control_unit.sv
// Image control unit: accepts one instruction in IDLE, strobes for one ISSUE cycle, waits MEM_LAT for loads.
// Define CU_ILLEGAL_TRAP_EN to lock into TRAP on an unsupported opcode until reset.
module img_control_unit
  import cu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int IMG_BYTES = 152100,
  parameter int STRIDE    = 4,
  parameter int MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [5:0]        alu_ctrl,
  output logic [2:0]        rs1,
  output logic [2:0]        rs2,
  output logic [2:0]        rd,
  output logic [7:0]        imm1,
  output logic [7:0]        imm2,
  output logic              rwe,
  output logic              rwe2,
  output logic              dm_we,
  output logic              im_we,
  output logic              im_rd,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [ADDR_W-1:0] im_raddr,
  output logic [1:0]        frame_done,
  output logic              illegal
);

  localparam int WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [5:0]        op_q, alu_q;
  logic [2:0]        rd_q, rs1_q, rs2_q;
  logic [7:0]        imm1_q, imm2_q;
  logic              accept, in_issue, rd_wrap, wr_wrap;
  logic              unused_rsvd;

  // Bit 16 is reserved in the instruction format.
  assign unused_rsvd = instr[16];

  assign instr_ready = (state_q == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign in_issue    = (state_q == ST_ISSUE);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (is_load(op_q)) begin
          state_d = ST_WAIT;
          wcnt_d  = WCNT_W'(MEM_LAT - 1);
        end
`ifdef CU_ILLEGAL_TRAP_EN
        else if (!is_legal(op_q)) state_d = ST_TRAP;
`endif
        else state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (wcnt_q == '0) state_d = ST_IDLE;
        else              wcnt_d  = wcnt_q - WCNT_W'(1);
      end
`ifdef CU_ILLEGAL_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      op_q    <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm1_q  <= '0;
      imm2_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept) begin
        op_q   <= instr[OPC_MSB:OPC_LSB];
        alu_q  <= alu_sel(instr[OPC_MSB:OPC_LSB]);
        rd_q   <= instr[RD_MSB:RD_LSB];
        rs1_q  <= instr[RS1_MSB:RS1_LSB];
        rs2_q  <= instr[RS2_MSB:RS2_LSB];
        imm1_q <= instr[IMM1_MSB:IMM1_LSB];
        imm2_q <= instr[IMM2_MSB:IMM2_LSB];
      end
    end
  end

  assign alu_ctrl = alu_q;
  assign rd       = rd_q;
  assign rs1      = rs1_q;
  assign rs2      = rs2_q;
  assign imm1     = imm1_q;
  assign imm2     = imm2_q;

  // Loads write back on the last WAIT cycle, when the memory data is valid.
  assign rwe   = (in_issue && is_alu(op_q)) || ((state_q == ST_WAIT) && (wcnt_q == '0));
  assign rwe2  = in_issue && (op_q == OP_MOV);
  assign dm_we = in_issue && (op_q == OP_STR_DAT);
  assign im_we = in_issue && (op_q == OP_STR_IMG);
  assign im_rd = in_issue && (op_q == OP_LDR_IMG);

`ifdef CU_ILLEGAL_TRAP_EN
  assign illegal = (in_issue && !is_legal(op_q)) || (state_q == ST_TRAP);
`else
  assign illegal = in_issue && !is_legal(op_q);
`endif

  img_addr_gen #(
    .ADDR_W   (ADDR_W),
    .IMG_BYTES(IMG_BYTES),
    .STRIDE   (STRIDE)
  ) u_raddr (
    .clk   (clk),
    .rst_n (rst_n),
    .step_i(im_rd),
    .addr_o(im_raddr),
    .wrap_o(rd_wrap)
  );

  img_addr_gen #(
    .ADDR_W   (ADDR_W),
    .IMG_BYTES(IMG_BYTES),
    .STRIDE   (STRIDE)
  ) u_waddr (
    .clk   (clk),
    .rst_n (rst_n),
    .step_i(im_we),
    .addr_o(im_waddr),
    .wrap_o(wr_wrap)
  );

  assign frame_done = {wr_wrap, rd_wrap};

endmodule

// File: tb/tb_img_control_unit.sv
// Bench for img_control_unit: directed table, hand-written reset/illegal sequences, random instructions vs. a reference model.
module tb_img_control_unit;

  localparam int ADDR_W    = 32;
  localparam int IMG_BYTES = 12;
  localparam int STRIDE    = 4;
  localparam int MEM_LAT   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [31:0]       instr = '0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [5:0]        alu_ctrl;
  logic [2:0]        rs1, rs2, rd;
  logic [7:0]        imm1, imm2;
  logic              rwe, rwe2, dm_we, im_we, im_rd;
  logic [ADDR_W-1:0] im_waddr, im_raddr;
  logic [1:0]        frame_done;
  logic              illegal;

  img_control_unit #(
    .ADDR_W(ADDR_W), .IMG_BYTES(IMG_BYTES), .STRIDE(STRIDE), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_ctrl(alu_ctrl), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm1(imm1), .imm2(imm2), .rwe(rwe), .rwe2(rwe2), .dm_we(dm_we), .im_we(im_we),
    .im_rd(im_rd), .im_waddr(im_waddr), .im_raddr(im_raddr), .frame_done(frame_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the outputs should currently be holding.
  int          m_raddr, m_waddr, last_raddr;
  logic [1:0]  fd_pend;
  logic [5:0]  h_alu;
  logic [24:0] h_fields;

  typedef struct {
    logic [31:0] ins;
    logic [5:0]  alu;
    logic [5:0]  strb;   // {rwe, rwe2, dm_we, im_we, im_rd, illegal} in the ISSUE cycle
    bit          load;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int r_d, input int r_s1, input int r_s2,
                                     input int i1, input int i2);
    logic [31:0] w;
    w = {op[5:0], r_d[2:0], r_s1[2:0], r_s2[2:0], 1'b0, i1[7:0], i2[7:0]};
    return w;
  endfunction

  function automatic logic [24:0] fld(input logic [31:0] w);
    return {w[25:23], w[22:20], w[19:17], w[15:8], w[7:0]};
  endfunction

  // Expected ISSUE behaviour of an opcode, straight from the opcode table.
  function automatic void model_exp(input int op, output logic [5:0] alu, output logic [5:0] strb,
                                    output bit load);
    alu = 6'd0; strb = 6'b000000; load = 1'b0;
    if (op == 1 || op == 2 || (op >= 4 && op <= 7)) begin alu = 6'(op); strb = 6'b100000; end
    else if (op == 3)  strb = 6'b010000;
    else if (op == 8)  strb = 6'b001000;
    else if (op == 10) strb = 6'b000100;
    else if (op == 9)  begin alu = 6'd9; load = 1'b1; end
    else if (op == 11) begin alu = 6'd11; strb = 6'b000010; load = 1'b1; end
    else strb = 6'b000001;
  endfunction

  task automatic check_cycle(input string tag, input logic rdy, input logic [5:0] strb);
    chk({tag, ".ready"}, 64'(instr_ready), 64'(rdy));
    chk({tag, ".strb"}, 64'({rwe, rwe2, dm_we, im_we, im_rd, illegal}), 64'(strb));
    chk({tag, ".alu"}, 64'(alu_ctrl), 64'(h_alu));
    chk({tag, ".fields"}, 64'({rd, rs1, rs2, imm1, imm2}), 64'(h_fields));
    chk({tag, ".raddr"}, 64'(im_raddr), 64'(m_raddr));
    chk({tag, ".waddr"}, 64'(im_waddr), 64'(m_waddr));
    chk({tag, ".fdone"}, 64'(frame_done), 64'(fd_pend));
    fd_pend = 2'b00;
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge of the next idle cycle.
  task automatic run_instr(input string tag, input logic [31:0] ins, input logic [5:0] alu_e,
                           input logic [5:0] strb_e, input bit load_e);
    int op;
    op = int'(ins[31:26]);
    check_cycle({tag, ".idle"}, 1'b1, 6'b000000);
    instr = ins; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; instr = $urandom();
    h_alu = alu_e; h_fields = fld(ins);
    last_raddr = int'(im_raddr);
    check_cycle({tag, ".issue"}, 1'b0, strb_e);
    if (op == 11) begin
      m_raddr += STRIDE;
      if (m_raddr >= IMG_BYTES) begin m_raddr = 0; fd_pend[0] = 1'b1; end
    end
    if (op == 10) begin
      m_waddr += STRIDE;
      if (m_waddr >= IMG_BYTES) begin m_waddr = 0; fd_pend[1] = 1'b1; end
    end
    if (load_e) begin
      for (int i = 1; i <= MEM_LAT; i++) begin
        @(negedge clk);
        check_cycle({tag, ".wait"}, 1'b0, (i == MEM_LAT) ? 6'b100000 : 6'b000000);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".ready"}, 64'(instr_ready), 64'd1);
    chk({tag, ".ctl"}, 64'({alu_ctrl, rs1, rs2, rd, imm1, imm2, rwe, rwe2, dm_we, im_we, im_rd,
                            frame_done, illegal}), 64'd0);
    chk({tag, ".addr"}, {im_raddr, im_waddr}, 64'd0);
  endtask

  // Starts and ends at a falling edge; checks the outputs 1 ns into the reset assertion.
  task automatic do_reset(input string tag);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    m_raddr = 0; m_waddr = 0; fd_pend = 2'b00; h_alu = '0; h_fields = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [5:0]  a_e, s_e;
    bit          l_e;
    logic [31:0] r;
    int          op;

    tbl[0]  = '{mk(1, 1, 2, 3, 8'h12, 8'h34),  6'd1,  6'b100000, 1'b0};
    tbl[1]  = '{mk(2, 7, 0, 5, 8'hFF, 8'h00),  6'd2,  6'b100000, 1'b0};
    tbl[2]  = '{mk(3, 4, 1, 1, 8'hA5, 8'h5A),  6'd0,  6'b010000, 1'b0};
    tbl[3]  = '{mk(4, 2, 3, 4, 8'h01, 8'h02),  6'd4,  6'b100000, 1'b0};
    tbl[4]  = '{mk(5, 3, 6, 7, 8'h80, 8'h7F),  6'd5,  6'b100000, 1'b0};
    tbl[5]  = '{mk(6, 5, 5, 2, 8'h0F, 8'hF0),  6'd6,  6'b100000, 1'b0};
    tbl[6]  = '{mk(7, 6, 4, 0, 8'h3C, 8'hC3),  6'd7,  6'b100000, 1'b0};
    tbl[7]  = '{mk(8, 0, 7, 6, 8'h11, 8'h22),  6'd0,  6'b001000, 1'b0};
    tbl[8]  = '{mk(9, 1, 1, 1, 8'h33, 8'h44),  6'd9,  6'b000000, 1'b1};
    tbl[9]  = '{mk(10, 2, 2, 2, 8'h55, 8'h66), 6'd0,  6'b000100, 1'b0};
    tbl[10] = '{mk(11, 3, 3, 3, 8'h77, 8'h88), 6'd11, 6'b000010, 1'b1};

    #2;
    do_reset("reset0");

    foreach (tbl[i]) run_instr($sformatf("vec%0d", i), tbl[i].ins, tbl[i].alu, tbl[i].strb, tbl[i].load);

    // Read-address walk from 0 with IMG_BYTES=12: 0, 4, 8, then back to 0.
    do_reset("reset1");
    for (int k = 0; k < 4; k++) begin
      run_instr($sformatf("wrap%0d", k), mk(11, k, 0, 0, k, k), 6'd11, 6'b000010, 1'b1);
      chk($sformatf("wrap%0d.issue_raddr", k), 64'(last_raddr), 64'((k * STRIDE) % IMG_BYTES));
    end

    // Reset in the middle of a load: no write-back, everything cleared at once.
    instr = mk(11, 5, 1, 2, 8'h9A, 8'hBC); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("rstwait.im_rd", 64'(im_rd), 64'd1);
    @(negedge clk);
    do_reset("rstwait");
    for (int i = 0; i < MEM_LAT + 2; i++) begin
      chk($sformatf("rstwait.after%0d.rwe", i), 64'(rwe), 64'd0);
      chk($sformatf("rstwait.after%0d.ready", i), 64'(instr_ready), 64'd1);
      @(negedge clk);
    end

    // Illegal opcodes around some address activity, so "counters unchanged" is meaningful.
    run_instr("pre_ill_st", mk(10, 0, 0, 0, 0, 0), 6'd0, 6'b000100, 1'b0);
    run_instr("pre_ill_ld", mk(11, 0, 0, 0, 0, 0), 6'd11, 6'b000010, 1'b1);
`ifdef CU_ILLEGAL_TRAP_EN
    instr = mk(63, 1, 2, 3, 8'hDE, 8'hAD); instr_valid = 1'b1;
    @(negedge clk);
    h_alu = 6'd0; h_fields = fld(mk(63, 1, 2, 3, 8'hDE, 8'hAD));
    check_cycle("trap.issue", 1'b0, 6'b000001);
    instr = mk(1, 1, 1, 1, 0, 0); instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_cycle($sformatf("trap.hold%0d", i), 1'b0, 6'b000001);
    end
    do_reset("trap.reset");
    chk("trap.ready_after_reset", 64'(instr_ready), 64'd1);
`else
    run_instr("ill63", mk(63, 1, 2, 3, 8'hDE, 8'hAD), 6'd0, 6'b000001, 1'b0);
    run_instr("ill0", mk(0, 4, 5, 6, 8'hBE, 8'hEF), 6'd0, 6'b000001, 1'b0);
    run_instr("ill12", mk(12, 7, 7, 7, 8'h01, 8'h10), 6'd0, 6'b000001, 1'b0);
`endif

    for (int n = 0; n < 300; n++) begin
      r = $urandom();
`ifdef CU_ILLEGAL_TRAP_EN
      op = $urandom_range(1, 11);
`else
      op = $urandom_range(0, 15);
      if (op == 15) op = $urandom_range(12, 63);
`endif
      model_exp(op, a_e, s_e, l_e);
      run_instr($sformatf("rnd%0d", n), {op[5:0], r[25:0]}, a_e, s_e, l_e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
